// File: rtl/timer_ctrl.sv
// timer_ctrl: round-robin scheduler and sequencer that shares one step counter
// among NREQ requesters, runs each owner's job (plus repeats) and reports done.
// Optional watchdog: define TIMER_CTRL_WATCHDOG_EN to abort runs that see no
// terminal event within TIMEOUT RUN cycles (err pulse instead of done).
module timer_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_mode,
  input  logic [NREQ-1:0]   req_up,
  input  logic [W*NREQ-1:0] req_start,
  input  logic [W*NREQ-1:0] req_limit,
  input  logic [4*NREQ-1:0] req_repeat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              cnt_load,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  output logic [2:0]        cnt_mode,
  output logic [W-1:0]      cnt_din,
  output logic [W-1:0]      cnt_sat_count,
  input  logic              cnt_event
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   owner, rr_ptr, next_ptr, pick;
  logic            found;
  logic [2:0]      mode_q, sel_mode;
  logic            up_q, sel_up;
  logic [W-1:0]    start_q, limit_q, sel_start, sel_limit;
  logic [3:0]      runs_left, sel_repeat;
  logic            owner_req;
  logic            wd_hit;

  assign owner_req = req[owner];
  assign next_ptr  = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  // Pick the first requester at or after the round-robin pointer and mux its config.
  always_comb begin
    int j;
    j          = 0;
    found      = 1'b0;
    pick       = '0;
    sel_mode   = '0;
    sel_up     = 1'b0;
    sel_start  = '0;
    sel_limit  = '0;
    sel_repeat = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        pick       = IW'(j);
        sel_mode   = req_mode[3*j +: 3];
        sel_up     = req_up[j];
        sel_start  = req_start[W*j +: W];
        sel_limit  = req_limit[W*j +: W];
        sel_repeat = req_repeat[4*j +: 4];
      end
    end
  end

`ifdef TIMER_CTRL_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] run_cnt;

  // Count RUN cycles of the current run; every load starts a fresh budget.
  always_ff @(posedge clk) begin
    if (!rst)                run_cnt <= '0;
    else if (state == LOAD)  run_cnt <= '0;
    else if (state == RUN)   run_cnt <= run_cnt + CW'(1);
  end

  assign wd_hit = (state == RUN) && !cnt_event && (run_cnt == CW'(TIMEOUT - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decision; an owner dropping its request wins over everything in RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (found) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN: begin
        if (!owner_req)     state_next = IDLE;
        else if (cnt_event) state_next = DONE;
        else if (wd_hit)    state_next = IDLE;
      end
      DONE:    state_next = (runs_left != 4'd0) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, latched configuration, repeat count and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      runs_left <= '0;
      mode_q    <= '0;
      up_q      <= 1'b0;
      start_q   <= '0;
      limit_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q     <= NREQ'(1) << pick;
            owner     <= pick;
            mode_q    <= sel_mode;
            up_q      <= sel_up;
            start_q   <= sel_start;
            limit_q   <= sel_limit;
            runs_left <= sel_repeat;
          end
        end
        RUN: begin
          if (!owner_req) begin
            gnt_q <= '0;
          end else if (wd_hit) begin
            gnt_q  <= '0;
            rr_ptr <= next_ptr;
          end
        end
        DONE: begin
          if (runs_left != 4'd0) begin
            runs_left <= runs_left - 4'd1;
          end else begin
            gnt_q  <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  // Counter controls and status outputs, config gated by ownership.
  always_comb begin
    gnt           = gnt_q;
    busy          = (state != IDLE);
    cnt_load      = (state == LOAD);
    cnt_enable    = (state == RUN) && !cnt_event;
    done          = ((state == DONE) && (runs_left == 4'd0)) ? gnt_q : '0;
    err           = (wd_hit && owner_req) ? gnt_q : '0;
    cnt_mode      = (|gnt_q) ? mode_q  : 3'd0;
    cnt_up_down   = (|gnt_q) ? up_q    : 1'b0;
    cnt_din       = (|gnt_q) ? start_q : '0;
    cnt_sat_count = (|gnt_q) ? limit_q : '0;
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl with a stand-in step counter,
// a run-length based reference model checked every cycle, and literal spot checks.
// Honours TIMER_CTRL_WATCHDOG_EN the same way as the design.
module tb_timer_ctrl;
  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;
`ifdef TIMER_CTRL_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [3*NREQ-1:0] req_mode = '0;
  logic [NREQ-1:0]   req_up = '0;
  logic [W*NREQ-1:0] req_start = '0;
  logic [W*NREQ-1:0] req_limit = '0;
  logic [4*NREQ-1:0] req_repeat = '0;
  logic [NREQ-1:0]   gnt, done, err;
  logic              busy, cnt_load, cnt_enable, cnt_up_down, cnt_event;
  logic [2:0]        cnt_mode;
  logic [W-1:0]      cnt_din, cnt_sat_count;

  logic [W-1:0]      ctr_count = '0;
  logic [W-1:0]      ctr_step;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_up(req_up),
    .req_start(req_start), .req_limit(req_limit), .req_repeat(req_repeat),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down),
    .cnt_mode(cnt_mode), .cnt_din(cnt_din), .cnt_sat_count(cnt_sat_count),
    .cnt_event(cnt_event)
  );

  always #5 clk = ~clk;

  assign ctr_step  = W'(cnt_mode) + W'(1);
  assign cnt_event = cnt_up_down ? (ctr_count == cnt_sat_count) : (ctr_count == '0);

  // Stand-in for the shared counter: load, then step toward the limit or zero with clipping.
  always @(posedge clk) begin
    if (cnt_load)
      ctr_count <= cnt_din;
    else if (cnt_enable) begin
      if (cnt_up_down)
        ctr_count <= (cnt_sat_count - ctr_count <= ctr_step) ? cnt_sat_count : ctr_count + ctr_step;
      else
        ctr_count <= (ctr_count <= ctr_step) ? '0 : ctr_count - ctr_step;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: a job is LOAD, then L RUN cycles, then DONE, with L from run-length arithmetic.
  bit          m_busy = 1'b0;
  int          m_owner, m_t, m_len, m_runs, m_rr, m_idx;
  bit          m_found;
  logic [2:0]  m_mode;
  logic        m_up;
  logic [W-1:0] m_start, m_limit;
  longint      m_dist, m_step;
  logic [NREQ-1:0] e_gnt, e_done, e_err;
  logic        e_busy, e_load, e_en, e_up;
  logic [2:0]  e_mode;
  logic [W-1:0] e_din, e_sat;

  initial begin : model_compare
    m_rr = 0;
    forever begin
      @(negedge clk);
      e_gnt = '0; e_done = '0; e_err = '0; e_busy = 1'b0; e_load = 1'b0; e_en = 1'b0;
      e_up = 1'b0; e_mode = '0; e_din = '0; e_sat = '0;
      if (m_busy) begin
        e_gnt  = NREQ'(1) << m_owner;
        e_busy = 1'b1; e_mode = m_mode; e_up = m_up; e_din = m_start; e_sat = m_limit;
        if (m_t == 0) e_load = 1'b1;
        else if (m_t <= m_len) begin
          e_en = (m_t != m_len);
          if (WD_ON && m_t == TIMEOUT && m_t < m_len && req[m_owner]) e_err = e_gnt;
        end else if (m_runs == 0) e_done = e_gnt;
      end
      checkOutput("gnt", 64'(gnt), 64'(e_gnt));
      checkOutput("done", 64'(done), 64'(e_done));
      checkOutput("err", 64'(err), 64'(e_err));
      checkOutput("busy", 64'(busy), 64'(e_busy));
      checkOutput("cnt_load", 64'(cnt_load), 64'(e_load));
      checkOutput("cnt_enable", 64'(cnt_enable), 64'(e_en));
      checkOutput("cnt_up_down", 64'(cnt_up_down), 64'(e_up));
      checkOutput("cnt_mode", 64'(cnt_mode), 64'(e_mode));
      checkOutput("cnt_din", 64'(cnt_din), 64'(e_din));
      checkOutput("cnt_sat_count", 64'(cnt_sat_count), 64'(e_sat));

      @(posedge clk);
      if (!rst) begin
        m_busy = 1'b0;
        m_rr   = 0;
      end else if (!m_busy) begin
        m_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          m_idx = (m_rr + k) % NREQ;
          if (!m_found && req[m_idx]) begin
            m_found = 1'b1;
            m_owner = m_idx;
          end
        end
        if (m_found) begin
          m_busy  = 1'b1;
          m_t     = 0;
          m_mode  = req_mode[3*m_owner +: 3];
          m_up    = req_up[m_owner];
          m_start = req_start[W*m_owner +: W];
          m_limit = req_limit[W*m_owner +: W];
          m_runs  = int'(req_repeat[4*m_owner +: 4]);
          m_step  = longint'(m_mode) + 1;
          m_dist  = m_up ? longint'(m_limit) - longint'(m_start) : longint'(m_start);
          m_len   = int'((m_dist + m_step - 1) / m_step) + 1;
        end
      end else if (m_t >= 1 && m_t <= m_len && !req[m_owner]) begin
        m_busy = 1'b0;
      end else if (WD_ON && m_t == TIMEOUT && m_t < m_len) begin
        m_busy = 1'b0;
        m_rr   = (m_owner + 1) % NREQ;
      end else if (m_t == m_len + 1) begin
        if (m_runs > 0) begin
          m_runs--;
          m_t = 0;
        end else begin
          m_busy = 1'b0;
          m_rr   = (m_owner + 1) % NREQ;
        end
      end else begin
        m_t++;
      end
    end
  end

  task automatic setCfg(input int i, input int mode, input bit up, input int start, input int limit, input int rep);
    req_mode[3*i +: 3]   = 3'(mode);
    req_up[i]            = up;
    req_start[W*i +: W]  = W'(start);
    req_limit[W*i +: W]  = W'(limit);
    req_repeat[4*i +: 4] = 4'(rep);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    req = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitDone(input logic [NREQ-1:0] who, input int budget);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < budget && !hit; c++) begin
      waitCycles(1);
      if ((done & who) != '0) hit = 1'b1;
    end
    checkOutput("done_within_budget", 64'(hit), 64'(1));
    applyStimulus(req & ~who);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    waitCycles(1);
    rst = 1'b1;
  endtask

  logic [NREQ-1:0] rr_order [5];

  initial begin : stimulus
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_gnt", 64'(gnt), 64'(0));
    rst = 1'b1;
    waitCycles(1);

    // Single up run 0..10 step 1.
    setCfg(0, 0, 1'b1, 0, 10, 0);
    applyStimulus(4'b0001);
    waitCycles(1);
    checkOutput("t1_gnt_c1", 64'(gnt), 64'(4'b0001));
    checkOutput("t1_load_c1", 64'(cnt_load), 64'(1));
    waitCycles(12);
    checkOutput("t1_done_c13", 64'(done), 64'(4'b0001));
    applyStimulus(4'b0000);
    waitCycles(1);
    checkOutput("t1_idle_c14", 64'(busy), 64'(0));

    // Down run from 10 step 4, then the same with two repeats.
    setCfg(1, 3, 1'b0, 10, 0, 0);
    applyStimulus(4'b0010);
    waitCycles(1);
    checkOutput("t2_din_c1", 64'(cnt_din), 64'(10));
    waitCycles(5);
    checkOutput("t2_done_c6", 64'(done), 64'(4'b0010));
    applyStimulus(4'b0000);
    waitCycles(1);
    setCfg(1, 3, 1'b0, 10, 0, 2);
    applyStimulus(4'b0010);
    waitCycles(6);
    checkOutput("t2r_nodone_c6", 64'(done), 64'(0));
    checkOutput("t2r_gnt_c6", 64'(gnt), 64'(4'b0010));
    waitCycles(1);
    checkOutput("t2r_reload_c7", 64'(cnt_load), 64'(1));
    waitCycles(11);
    checkOutput("t2r_done_c18", 64'(done), 64'(4'b0010));
    applyStimulus(4'b0000);
    waitCycles(1);

    // All four requesting continuously from a fresh pointer.
    applyReset();
    for (int i = 0; i < NREQ; i++) setCfg(i, 0, 1'b1, 0, 2, 0);
    applyStimulus(4'b1111);
    for (int n = 0; n < 5; n++) begin
      waitCycles(n == 0 ? 1 : 6);
      checkOutput("rr_grant_order", 64'(gnt), 64'(rr_order[n]));
    end
    applyStimulus(4'b0000);
    waitCycles(3);

    // Owner 2 drops mid-run, owner 3 is served next.
    setCfg(2, 0, 1'b1, 0, 50, 0);
    setCfg(3, 0, 1'b1, 0, 2, 0);
    applyStimulus(4'b1100);
    waitCycles(1);
    checkOutput("t4_gnt2_c1", 64'(gnt), 64'(4'b0100));
    waitCycles(4);
    applyStimulus(4'b1000);
    waitCycles(1);
    checkOutput("t4_enable_off", 64'(cnt_enable), 64'(0));
    checkOutput("t4_no_done", 64'(done), 64'(0));
    waitCycles(1);
    checkOutput("t4_gnt3_c7", 64'(gnt), 64'(4'b1000));
    waitDone(4'b1000, 20);
    waitCycles(1);

    // Reset in the middle of a run, then requester 0 must win over 3.
    setCfg(3, 0, 1'b1, 0, 50, 0);
    applyStimulus(4'b1000);
    waitCycles(5);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("t5_rst_gnt", 64'(gnt), 64'(0));
    checkOutput("t5_rst_busy", 64'(busy), 64'(0));
    checkOutput("t5_rst_enable", 64'(cnt_enable), 64'(0));
    checkOutput("t5_rst_din", 64'(cnt_din), 64'(0));
    setCfg(0, 0, 1'b1, 5, 7, 0);
    applyStimulus(4'b1001);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("t5_gnt0_first", 64'(gnt), 64'(4'b0001));
    waitDone(4'b0001, 20);
    waitDone(4'b1000, 100);
    waitCycles(1);

    // Long up run to 1000: watchdog abort or plain completion.
    setCfg(1, 0, 1'b1, 0, 1000, 0);
    applyStimulus(4'b0010);
`ifdef TIMER_CTRL_WATCHDOG_EN
    waitCycles(17);
    checkOutput("t6_err_c17", 64'(err), 64'(4'b0010));
    checkOutput("t6_no_done", 64'(done), 64'(0));
    applyStimulus(4'b0000);
    waitCycles(2);
    checkOutput("t6_idle", 64'(busy), 64'(0));
`else
    waitCycles(1003);
    checkOutput("t6_done_c1003", 64'(done), 64'(4'b0010));
    applyStimulus(4'b0000);
    waitCycles(2);
    checkOutput("t6_idle", 64'(busy), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
